// File: rtl/asi_pkg.sv
// Shared definitions for the ASI user-side arbiter: arbitration modes,
// arbiter state encoding and the last-served marker.
package asi_pkg;

  localparam int unsigned ARB_WPRI = 0;
  localparam int unsigned ARB_RPRI = 1;
  localparam int unsigned ARB_RR   = 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StROwn   = 3'd1,
    StRBurst = 3'd2,
    StWOwn   = 3'd3,
    StWBurst = 3'd4
  } arb_st_t;

  // Which engine completed the most recent burst (round-robin memory).
  typedef enum logic {
    SrvRd = 1'b0,
    SrvWr = 1'b1
  } srv_t;

endpackage

// File: rtl/asi_arb_pick.sv
// Combinational arbitration between the read and write engines.
module asi_arb_pick
  import asi_pkg::*;
(
  input  logic       rreq,
  input  logic       wreq,
  input  logic [1:0] mode,
  input  srv_t       last_srv,
  output logic       pick_r,
  output logic       pick_w
);

  // Single requester always wins; ties resolved by the configured mode.
  always_comb begin
    pick_r = 1'b0;
    pick_w = 1'b0;
    if (rreq && wreq) begin
      if (mode == 2'(ARB_RPRI)) begin
        pick_r = 1'b1;
      end else if (mode == 2'(ARB_RR)) begin
        // Favour the side that was not served last.
        pick_r = (last_srv == SrvWr);
        pick_w = (last_srv == SrvRd);
      end else begin
        pick_w = 1'b1;
      end
    end else begin
      pick_r = rreq;
      pick_w = wreq;
    end
  end

endmodule

// File: rtl/asi_usr_arb.sv
// Burst-level arbiter between the ASI read and write engines, steering the
// owning engine's beats onto a single-port memory interface.
module asi_usr_arb
  import asi_pkg::*;
#(
  parameter int unsigned AXI_DW     = 128,
  parameter int unsigned AXI_AW     = 32,
  parameter int unsigned AXI_WSTRBW = AXI_DW / 8,
  parameter int unsigned ASI_ARB    = ARB_WPRI
) (
  input  logic                  usr_clk,
  input  logic                  usr_reset,
  input  logic                  usr_rrequest,
  output logic                  usr_rgrant,
  input  logic                  usr_re,
  input  logic                  usr_rlast,
  input  logic [AXI_AW-1:0]     usr_raddr,
  input  logic                  usr_wrequest,
  output logic                  usr_wgrant,
  input  logic                  usr_we,
  input  logic                  usr_wlast,
  input  logic [AXI_AW-1:0]     usr_waddr,
  input  logic [AXI_DW-1:0]     usr_wdata,
  input  logic [AXI_WSTRBW-1:0] usr_wstrb,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [AXI_AW-1:0]     mem_addr,
  output logic [AXI_DW-1:0]     mem_wdata,
  output logic [AXI_WSTRBW-1:0] mem_wstrb,
  output logic                  arb_err
);

  arb_st_t state_q, state_d, pick_st;
  srv_t    last_srv_q, last_srv_d;
  logic    arb_err_q, arb_err_d;
  logic    pick_r, pick_w;
  logic    r_done, w_done;

  assign usr_rgrant = (state_q == StROwn) || (state_q == StRBurst);
  assign usr_wgrant = (state_q == StWOwn) || (state_q == StWBurst);
  assign arb_err    = arb_err_q;

  // A burst completes only when its owner presents the last beat.
  assign r_done = usr_rgrant & usr_re & usr_rlast;
  assign w_done = usr_wgrant & usr_we & usr_wlast;

  // Round-robin memory follows the burst completing this cycle, so the
  // hand-over pick already sees the updated value.
  always_comb begin
    last_srv_d = last_srv_q;
    if (r_done) begin
      last_srv_d = SrvRd;
    end else if (w_done) begin
      last_srv_d = SrvWr;
    end
  end

  asi_arb_pick u_pick (
    .rreq     (usr_rrequest),
    .wreq     (usr_wrequest),
    .mode     (2'(ASI_ARB)),
    .last_srv (last_srv_d),
    .pick_r   (pick_r),
    .pick_w   (pick_w)
  );

  assign pick_st = pick_r ? StROwn : (pick_w ? StWOwn : StIdle);

  // Ownership FSM: a grant is held from first beat until the last beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = pick_st;
      StROwn: begin
        if (usr_re) begin
          state_d = usr_rlast ? pick_st : StRBurst;
        end else if (!usr_rrequest) begin
          state_d = pick_st;
        end
      end
      StRBurst: if (usr_re && usr_rlast) state_d = pick_st;
      StWOwn: begin
        if (usr_we) begin
          state_d = usr_wlast ? pick_st : StWBurst;
        end else if (!usr_wrequest) begin
          state_d = pick_st;
        end
      end
      StWBurst: if (usr_we && usr_wlast) state_d = pick_st;
      default:  state_d = StIdle;
    endcase
  end

  // Sticky error: any beat (including a qualified last beat) without ownership.
  always_comb begin
    arb_err_d = arb_err_q | (usr_re & ~usr_rgrant) | (usr_we & ~usr_wgrant);
  end

  // Memory port steering, gated by the registered grants.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (usr_rgrant) begin
      mem_en   = usr_re;
      mem_addr = usr_raddr;
    end else if (usr_wgrant) begin
      mem_en    = usr_we;
      mem_wr    = 1'b1;
      mem_addr  = usr_waddr;
      mem_wdata = usr_wdata;
      mem_wstrb = usr_wstrb;
    end
  end

  // State registers with synchronous reset; reset aborts any burst at once.
  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      state_q    <= StIdle;
      last_srv_q <= SrvWr;
      arb_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_srv_q <= last_srv_d;
      arb_err_q  <= arb_err_d;
    end
  end

endmodule
